// File: rtl/prbs_ber_pkg.sv
// prbs_ber_pkg: shared definitions for the PRBS bit-error-rate engine.
//   ber_state_e : measurement state encoding
//   lfsr_taps   : two-tap feedback mask for each supported polynomial order
//   order_legal : true for the supported LFSR orders
//   LFSR_SEED   : LFSR load value after reset or after an all-zero lockup
//   HIST_DEPTH  : depth of the launched-bit history (max LOOP_DELAY + 1)
package prbs_ber_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ber_state_e;

  localparam int MAX_ORDER  = 15;
  localparam int HIST_DEPTH = 16;

  localparam logic [MAX_ORDER-1:0] LFSR_SEED = 15'd1;

  // Tap n of the polynomial maps to register bit n-1.
  function automatic logic [MAX_ORDER-1:0] lfsr_taps(input int order);
    case (order)
      7:       lfsr_taps = 15'h0060;  // taps 7,6
      9:       lfsr_taps = 15'h0110;  // taps 9,5
      10:      lfsr_taps = 15'h0240;  // taps 10,7
      15:      lfsr_taps = 15'h6000;  // taps 15,14
      default: lfsr_taps = 15'h0000;
    endcase
  endfunction

  function automatic bit order_legal(input int order);
    return (order == 7) || (order == 9) || (order == 10) || (order == 15);
  endfunction

endpackage

// File: rtl/bit_rate_divider.sv
// bit_rate_divider: free-running 0..DIV-1 counter that produces the bit
// launch and receiver sample clock enables.
//   clk_i    : system clock
//   rst_i    : synchronous active-high reset (counter returns to 0)
//   launch_o : high while the count is 0
//   sample_o : high while the count is SAMPLE_PHASE
module bit_rate_divider #(
  parameter int DIV          = 16,
  parameter int SAMPLE_PHASE = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic launch_o,
  output logic sample_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(DIV - 1)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign launch_o = (cnt_q == '0);
  assign sample_o = (cnt_q == CW'(SAMPLE_PHASE));

endmodule

// File: rtl/prbs_ber_engine.sv
// prbs_ber_engine: transmits a PRBS on o_PRBS and measures the bit error
// rate of the looped-back i_ReceivedSignal over one window of bits.
//   CLK              : system clock
//   i_Reset          : synchronous active-high reset
//   i_Start          : one-cycle request to start a measurement
//   i_ReceivedSignal : receiver comparator output, synchronous to CLK
//   o_PRBS           : laser drive bit (LFSR MSB)
//   o_BitTick        : one-cycle pulse when a new bit is launched
//   o_Busy / o_Done  : measurement running / finished
//   o_Error          : one-cycle pulse per counted mismatch
//   o_BitCount       : compared bits, o_ErrorCount: mismatched bits
//   o_Saturated      : sticky, set when either counter saturates
//
// state   | meaning
// IDLE    | no measurement since reset; PRBS still transmitted
// RUN     | pipeline fill, then counting sample points
// DONE    | window complete; counters hold
module prbs_ber_engine
  import prbs_ber_pkg::*;
#(
  parameter int CLK_HZ       = 16000000,
  parameter int BPS          = 1000000,
  parameter int LFSR_ORDER   = 10,
  parameter int SAMPLE_PHASE = (CLK_HZ / BPS) / 2,
  parameter int LOOP_DELAY   = 0,
  parameter int WINDOW_BITS  = (1 << LFSR_ORDER) - 1,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             i_Reset,
  input  logic             i_Start,
  input  logic             i_ReceivedSignal,
  output logic             o_PRBS,
  output logic             o_BitTick,
  output logic             o_Busy,
  output logic             o_Done,
  output logic             o_Error,
  output logic [CNT_W-1:0] o_BitCount,
  output logic [CNT_W-1:0] o_ErrorCount,
  output logic             o_Saturated
);

  localparam int DIV = CLK_HZ / BPS;

  // A counter narrower than the window is accepted on purpose: it saturates,
  // raises o_Saturated, and the measurement then never completes.
  if (DIV < 4) begin : g_bad_div
    $fatal(1, "prbs_ber_engine: CLK_HZ/BPS must be at least 4");
  end
  if (!order_legal(LFSR_ORDER)) begin : g_bad_order
    $fatal(1, "prbs_ber_engine: LFSR_ORDER must be 7, 9, 10 or 15");
  end
  if (SAMPLE_PHASE < 1 || SAMPLE_PHASE > DIV - 1) begin : g_bad_phase
    $fatal(1, "prbs_ber_engine: SAMPLE_PHASE must be in 1..DIV-1");
  end
  if (LOOP_DELAY < 0 || LOOP_DELAY >= HIST_DEPTH) begin : g_bad_delay
    $fatal(1, "prbs_ber_engine: LOOP_DELAY must be in 0..15");
  end
  if (WINDOW_BITS < 1) begin : g_bad_window
    $fatal(1, "prbs_ber_engine: WINDOW_BITS must be positive");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cntw
    $fatal(1, "prbs_ber_engine: CNT_W must be in 1..32");
  end

  localparam logic [MAX_ORDER-1:0]  TAPS_ALL   = lfsr_taps(LFSR_ORDER);
  localparam logic [LFSR_ORDER-1:0] TAPS       = TAPS_ALL[LFSR_ORDER-1:0];
  localparam logic [LFSR_ORDER-1:0] SEED       = LFSR_SEED[LFSR_ORDER-1:0];
  localparam logic [CNT_W-1:0]      CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [31:0]           WINDOW_END = 32'(WINDOW_BITS);

  logic launch_en, sample_en;

  bit_rate_divider #(
    .DIV          (DIV),
    .SAMPLE_PHASE (SAMPLE_PHASE)
  ) u_div (
    .clk_i    (CLK),
    .rst_i    (i_Reset),
    .launch_o (launch_en),
    .sample_o (sample_en)
  );

  // Transmitter: runs from reset release regardless of the measurement state.
  logic [LFSR_ORDER-1:0] lfsr_q, lfsr_d;
  logic [HIST_DEPTH-1:0] hist_q;   // bit 0 always equals o_PRBS
  logic                  bit_tick_q;

  always_comb begin
    lfsr_d = lfsr_q;
    if (launch_en) begin
      if (lfsr_q == '0) lfsr_d = SEED;
      else              lfsr_d = {lfsr_q[LFSR_ORDER-2:0], ^(lfsr_q & TAPS)};
    end
  end

  always_ff @(posedge CLK) begin
    if (i_Reset) begin
      lfsr_q     <= SEED;
      hist_q     <= '0;
      bit_tick_q <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_d;
      bit_tick_q <= launch_en;
      if (launch_en) hist_q <= (hist_q << 1) | HIST_DEPTH'(lfsr_d[LFSR_ORDER-1]);
    end
  end

  // Receiver / measurement FSM.
  ber_state_e       state_q;
  logic             busy_q, done_q, err_q, sat_q;
  logic [CNT_W-1:0] bit_cnt_q, err_cnt_q;
  logic [4:0]       fill_q;
  logic             mismatch;

  assign mismatch = i_ReceivedSignal != hist_q[LOOP_DELAY];

  always_ff @(posedge CLK) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      sat_q     <= 1'b0;
      bit_cnt_q <= '0;
      err_cnt_q <= '0;
      fill_q    <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // A sample point coinciding with i_Start is dropped here.
          if (i_Start) begin
            state_q   <= ST_RUN;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            sat_q     <= 1'b0;
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
            fill_q    <= '0;
          end
        end
        ST_RUN: begin
          if (32'(bit_cnt_q) == WINDOW_END) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (sample_en) begin
            // Discard the first LOOP_DELAY+1 samples while the link fills.
            if (fill_q <= 5'(LOOP_DELAY)) begin
              fill_q <= fill_q + 5'd1;
            end else begin
              if (bit_cnt_q != CNT_MAX) bit_cnt_q <= bit_cnt_q + CNT_ONE;
              if (bit_cnt_q == CNT_MAX - CNT_ONE) sat_q <= 1'b1;
              if (mismatch) begin
                err_q <= 1'b1;
                if (err_cnt_q != CNT_MAX) err_cnt_q <= err_cnt_q + CNT_ONE;
                if (err_cnt_q == CNT_MAX - CNT_ONE) sat_q <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_PRBS       = lfsr_q[LFSR_ORDER-1];
  assign o_BitTick    = bit_tick_q;
  assign o_Busy       = busy_q;
  assign o_Done       = done_q;
  assign o_Error      = err_q;
  assign o_BitCount   = bit_cnt_q;
  assign o_ErrorCount = err_cnt_q;
  assign o_Saturated  = sat_q;

endmodule
